// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// States: IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold result until taken).
package alu_arb_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_XOR = 2'b01,
        OP_MUL = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant: zero latency, grant is one-hot or zero.
// Under contention the requester that did not win last time is chosen.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last_grant,
    output logic [NREQ-1:0] grant,
    output logic            grant_idx
);

    always_comb begin
        grant     = '0;
        grant_idx = 1'b0;
        if (req[0] && req[1]) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req[1];
        end
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbitro.sv
// Round-robin sequencer sharing one external ALU between two requesters; accept -> rsp_valid two cycles later,
// one op per 3 cycles, response held under back-pressure. Optional grant counters: ALU_ARB_STATS_EN.
module alu_arbitro
    import alu_arb_pkg::*;
#(
    parameter int A_W    = 2,
    parameter int B_W    = 4,
    parameter int Y_W    = 4,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [A_W-1:0]    req0_a,
    input  logic [A_W-1:0]    req1_a,
    input  logic [B_W-1:0]    req0_b,
    input  logic [B_W-1:0]    req1_b,
    input  logic [1:0]        req0_op,
    input  logic [1:0]        req1_op,
    output logic [A_W-1:0]    alu_a,
    output logic [B_W-1:0]    alu_b,
    output logic [1:0]        alu_op,
    input  logic [Y_W-1:0]    alu_y,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [Y_W-1:0]    rsp_y,
    output logic              rsp_z,
    output logic              rsp_n,
    output logic              rsp_c,
    output logic              rsp_v,
    output logic              busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
`endif
);

    state_t          state;
    op_t             op_q;
    logic            last_grant;
    logic [NREQ-1:0] grant;
    logic            grant_idx;

    if (STAT_W < 1) begin : g_stat_w_chk
        $error("STAT_W must be at least 1");
    end

    rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);
    assign alu_op    = op_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_v      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            op_q       <= OP_AND;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        if (grant_idx) begin
                            alu_a <= req1_a;
                            alu_b <= req1_b;
                            op_q  <= op_t'(req1_op);
                        end else begin
                            alu_a <= req0_a;
                            alu_b <= req0_b;
                            op_q  <= op_t'(req0_op);
                        end
                        state <= EXEC;
                    end
                end
                // Operands have been stable from the registers for a full cycle here.
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_z     <= alu_z;
                    rsp_n     <= alu_n;
                    rsp_c     <= alu_c;
                    rsp_v     <= alu_v;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (state == IDLE) begin
            if (grant[0] && (grant_cnt0 != {STAT_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (grant[1] && (grant_cnt1 != {STAT_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbitro.sv
// Directed bench for alu_arbitro with a small behavioural ALU standing in for the external datapath.
module tb_alu_arbitro;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req0_a, req1_a;
    logic [3:0] req0_b, req1_b;
    logic [1:0] req0_op, req1_op;
    logic [1:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_y;
    logic       alu_z, alu_n, alu_c, alu_v;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_y;
    logic       rsp_z, rsp_n, rsp_c, rsp_v;
    logic       busy;
`ifdef ALU_ARB_STATS_EN
    logic [1:0] grant_cnt0, grant_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    alu_arbitro #(.A_W(2), .B_W(4), .Y_W(4), .STAT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req1_a    (req1_a),
        .req0_b    (req0_b),
        .req1_b    (req1_b),
        .req0_op   (req0_op),
        .req1_op   (req1_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_z     (rsp_z),
        .rsp_n     (rsp_n),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v),
        .busy      (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    // Reference ALU: A zero-extended to 4 bits, result truncated to 4 bits.
    always_comb begin
        logic [4:0] wide;
        logic [7:0] prod;
        wide  = 5'd0;
        prod  = 8'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            2'b00: alu_y = {2'b00, alu_a} & alu_b;
            2'b01: alu_y = {2'b00, alu_a} ^ alu_b;
            2'b10: begin
                prod  = {6'd0, alu_a} * {4'd0, alu_b};
                alu_y = prod[3:0];
                alu_c = |prod[7:4];
            end
            default: begin
                wide  = {3'b000, alu_a} - {1'b0, alu_b};
                alu_y = wide[3:0];
                alu_c = wide[4];
                alu_v = alu_b[3] & wide[3];
            end
        endcase
        alu_z = (alu_y == 4'd0);
        alu_n = alu_y[3];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);

        // Contention: both valid every cycle, grants alternate starting with req0
        tick();
        req0_a = 2'b01; req0_b = 4'b1010; req0_op = 2'b01;
        req1_a = 2'b11; req1_b = 4'b0011; req1_op = 2'b10;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            tick();
            @(negedge clk);
            chk("cont_valid", rsp_valid, 1);
            chk("cont_id", rsp_id, k % 2);
            chk("cont_y", rsp_y, (k % 2 == 0) ? 4'b1011 : 4'b1001);
            chk("cont_n", rsp_n, 1);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;

        // Single AND from req0
        tick();
        req0_a = 2'b10; req0_b = 4'b1101; req0_op = 2'b00;
        req_valid = 2'b01;
        @(negedge clk);
        chk("and_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("and_exec_valid", rsp_valid, 0);
        chk("and_exec_busy", busy, 1);
        chk("and_alu_a", alu_a, 2'b10);
        chk("and_alu_b", alu_b, 4'b1101);
        chk("and_alu_op", alu_op, 2'b00);
        tick();
        @(negedge clk);
        chk("and_valid", rsp_valid, 1);
        chk("and_id", rsp_id, 0);
        chk("and_y", rsp_y, 4'b0000);
        chk("and_z", rsp_z, 1);
        chk("and_n", rsp_n, 0);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("and_hold_valid", rsp_valid, 1);
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("and_done_valid", rsp_valid, 0);
        chk("and_done_busy", busy, 0);

        // Back-pressure: SUB held for 5 cycles, no new requests accepted
        tick();
        req0_a = 2'b10; req0_b = 4'b0011; req0_op = 2'b11;
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_ready_accept", req_ready, 2'b01);
        tick();
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_y", rsp_y, 4'b1111);
            chk("bp_n", rsp_n, 1);
            chk("bp_c", rsp_c, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready_blocked", req_ready, 2'b00);
            tick();
            req0_a = 2'(i);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_valid", rsp_valid, 0);
        chk("bp_alu_op_kept", alu_op, 2'b11);

        // Reset during EXEC drops the op; pending req1 granted afterwards
        tick();
        req1_a = 2'b11; req1_b = 4'b1111; req1_op = 2'b00;
        req_valid = 2'b10;
        @(negedge clk);
        chk("mid_ready", req_ready, 2'b10);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_exec_busy", busy, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_b", alu_b, 0);
        chk("mid_alu_op", alu_op, 0);
        chk("mid_rsp_y", rsp_y, 0);
        chk("mid_rsp_z", rsp_z, 0);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_regrant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        @(negedge clk);
        chk("mid_rsp_valid2", rsp_valid, 1);
        chk("mid_rsp_id2", rsp_id, 1);
        chk("mid_rsp_y2", rsp_y, 4'b0011);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

`ifdef ALU_ARB_STATS_EN
        // Grant counters saturate at all-ones
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("stat_rst_cnt0", grant_cnt0, 0);
        chk("stat_rst_cnt1", grant_cnt1, 0);
        rsp_ready = 1'b1;
        req0_op = 2'b01;
        for (int g = 0; g < 5; g++) begin
            req_valid = 2'b01;
            tick();
            req_valid = 2'b00;
            tick();
            tick();
        end
        @(negedge clk);
        chk("stat_cnt0_sat", grant_cnt0, 2'b11);
        chk("stat_cnt1", grant_cnt1, 2'b00);
        rsp_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
